fft_axil_slave_regs: RTL
========================

Name: fft_axil_slave_regs

Overview:
- AXI4-Lite slave (responder) register file for the parallel-butterfly FFT IP; the S00_AXI port that the master BFM/PS drives.
- Decodes single-beat writes/reads into 4 RW control/config registers plus read-only status and ID words.
- Drives the FFT core's start pulse and configuration outputs, and captures its busy/done status.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
- C_IP_ID, 32'hFF7_0001, constant returned at 0x14.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake.
- fft_start  out  1  one-cycle start pulse.
- fft_cfg0, fft_cfg1, fft_cfg2  out  32 each  contents of REG1..REG3.
- fft_busy  in  1  live busy level from the core.
- fft_done  in  1  one-cycle done pulse from the core.

Behaviour:
- Reset is synchronous, active-high.
  - All outputs reset to 0: ready, valid, resp, rdata, fft_start, cfg.
  - All registers reset to 0, including the done sticky bit.
  - Any in-flight AW, W, AR or response is discarded.
  - The ready signals rise in the first cycle after reset deasserts.
- Register map (word index = addr[4:2]; addr[1:0] ignored):
  - 0x00 CTRL, RW, 32b stored.
  - 0x04 CFG0, RW.
  - 0x08 CFG1, RW.
  - 0x0C CFG2, RW.
  - 0x10 STATUS, RO: bit0 = fft_busy (live), bit1 = done sticky, bits 31:2 = 0.
  - 0x14 ID, RO, returns C_IP_ID.
  - 0x18 and 0x1C are unmapped.
- Write FSM states: WR_IDLE, WR_RESP.
  - In WR_IDLE, AW and W are accepted independently. awready/wready are each high until their own beat is captured, then low.
  - When both are captured, the write commits on the next edge and the FSM enters WR_RESP with bvalid=1. Register contents are visible in the same cycle bvalid rises.
  - Latency: bvalid is high 1 cycle after the later of the AW/W handshakes.
  - bvalid and bresp hold until bready; then return to WR_IDLE, with ready high again the next cycle. One outstanding write.
  - wstrb[k] gates byte k on RW registers.
  - Write to CTRL with wstrb[0]=1 and wdata[0]=1: fft_start=1 for exactly the commit cycle. The CTRL value is stored as written (readback is the written value).
  - Write to STATUS: bit1 is write-1-to-clear (gated by wstrb[0]); all other bits ignored; bresp=OKAY.
  - Write to ID: ignored, bresp=OKAY.
  - Write to an unmapped address: no state change, bresp=SLVERR (2'b10).
- Read FSM states: RD_IDLE, RD_DATA.
  - arready=1 in RD_IDLE.
  - On AR handshake, rdata is registered from current register state and rvalid=1 the next cycle.
  - rdata, rresp and rvalid hold until rready; arready=0 while in RD_DATA.
  - Unmapped address: rdata=0, rresp=SLVERR.
- Simultaneous events:
  - Read and write commit to the same register in the same cycle: the read returns the pre-write value.
  - fft_done pulse in the same cycle as a W1C clear of bit1: set wins, bit1 stays 1.
  - The read and write channels are fully independent; both may complete in the same cycle.

Decomposition:
- Package fft_axil_pkg holds:
  - Register offset constants (REG_CTRL..REG_ID).
  - Response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - wr_state_t and rd_state_t enums.
- No sub-module. Write channel, read channel and register file live in one module; a byte-strobe merge function goes in the package.

Test Plan:
- Sequential writes of 1, 2, 3, 4 to 0x00, 0x04, 0x08, 0x0C, then reads of those addresses -> rdata 1, 2, 3, 4, all rresp OKAY. fft_start pulses exactly once (CTRL write of 1); fft_cfg0..2 = 2, 3, 4.
- awvalid asserted 3 cycles before wvalid, addr 0x04, data 32'hA5A5_0000 -> awready drops after AW capture; bvalid exactly 1 cycle after the W handshake. Then hold bready low 5 cycles -> bvalid and bresp stable, no second write accepted.
- CFG1 = 32'h1122_3344, then write 32'hFFFF_FFFF with wstrb=4'b0010 -> readback 32'h1122_FF44.
- Write to 0x18 and read from 0x1C -> bresp=2'b10, rresp=2'b10, rdata=0, no register changes.
- fft_done pulse -> STATUS reads 32'h2 (32'h3 if busy). W1C of 32'h2 in the same cycle as a new fft_done -> bit1 remains 1; W1C alone next -> bit1 cleared.
- Assert s00_axi_areset while bvalid is pending and an AR is captured -> next cycle all valids 0 and registers 0; after release, awready/wready/arready = 1 and a fresh transaction completes normally.

Source files
------------

// File: rtl/fft_axil_slave_regs_pkg.sv
// Shared constants, channel state types and the byte-strobe merge helper
// for the FFT AXI4-Lite register slave.
package fft_axil_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_CFG0   = 5'h04;
  localparam logic [4:0] REG_CFG1   = 5'h08;
  localparam logic [4:0] REG_CFG2   = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_ID     = 5'h14;

  // Word indices derived from the byte offsets, used by the address decoders.
  localparam logic [2:0] IDX_CTRL   = REG_CTRL[4:2];
  localparam logic [2:0] IDX_CFG0   = REG_CFG0[4:2];
  localparam logic [2:0] IDX_CFG1   = REG_CFG1[4:2];
  localparam logic [2:0] IDX_CFG2   = REG_CFG2[4:2];
  localparam logic [2:0] IDX_STATUS = REG_STATUS[4:2];
  localparam logic [2:0] IDX_ID     = REG_ID[4:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_axil_slave_regs_if.sv
// AXI4-Lite bus bundle for the FFT register slave (S00_AXI).
interface fft_axil_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fft_axil_slave_regs.sv
// AXI4-Lite register slave for the FFT core: CTRL/CFG0..2 RW, STATUS and ID RO.
// Independent single-outstanding write and read channels, all outputs registered.
module fft_axil_slave_regs
  import fft_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_IP_ID            = 32'h0FF7_0001
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  fft_axil_if.slave                     s00_axi,
  output logic                          fft_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0] fft_cfg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] fft_cfg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] fft_cfg2,
  input  logic                          fft_busy,
  input  logic                          fft_done
);

  wr_state_t                     r_wr_state;
  rd_state_t                     r_rd_state;
  logic                          r_awready, r_wready, r_bvalid;
  logic                          r_aw_have, r_w_have;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic [1:0]                    r_bresp;
  logic                          r_arready, r_rvalid;
  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;
  logic [31:0]                   r_rw [4];
  logic                          r_done;
  logic                          r_fft_start;

  logic [2:0]  w_wr_idx, w_rd_idx;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic        w_unused;

  assign w_wr_idx = r_awaddr[4:2];
  assign w_rd_idx = s00_axi.araddr[4:2];
  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, r_awaddr[1:0], s00_axi.araddr[1:0]};

  // Write channel, register file and done-sticky bit.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_wr_state  <= WR_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_aw_have   <= 1'b0;
      r_w_have    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_done      <= 1'b0;
      r_fft_start <= 1'b0;
      for (int i = 0; i < 4; i++) r_rw[i] <= '0;
    end else begin
      r_fft_start <= 1'b0;
      case (r_wr_state)
        WR_IDLE: begin
          if (r_aw_have && r_w_have) begin
            r_aw_have  <= 1'b0;
            r_w_have   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= RESP_OKAY;
            r_wr_state <= WR_RESP;
            case (w_wr_idx)
              IDX_CTRL, IDX_CFG0, IDX_CFG1, IDX_CFG2: begin
                r_rw[w_wr_idx[1:0]] <= strb_merge(r_rw[w_wr_idx[1:0]], r_wdata, r_wstrb);
                if (w_wr_idx == IDX_CTRL && r_wstrb[0] && r_wdata[0]) r_fft_start <= 1'b1;
              end
              IDX_STATUS: if (r_wstrb[0] && r_wdata[1]) r_done <= 1'b0;
              IDX_ID:     ;
              default:    r_bresp <= RESP_SLVERR;
            endcase
          end else begin
            if (r_awready && s00_axi.awvalid) begin
              r_awaddr  <= s00_axi.awaddr;
              r_aw_have <= 1'b1;
              r_awready <= 1'b0;
            end else if (!r_aw_have) begin
              r_awready <= 1'b1;
            end
            if (r_wready && s00_axi.wvalid) begin
              r_wdata  <= s00_axi.wdata;
              r_wstrb  <= s00_axi.wstrb;
              r_w_have <= 1'b1;
              r_wready <= 1'b0;
            end else if (!r_w_have) begin
              r_wready <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (s00_axi.bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
      endcase
      // NOTE: the last non-blocking assignment in a block wins, so placing the
      // done-set after the W1C makes a coincident done pulse override the clear.
      if (fft_done) r_done <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_rd_idx)
      IDX_CTRL, IDX_CFG0, IDX_CFG1, IDX_CFG2: w_rd_data = r_rw[w_rd_idx[1:0]];
      IDX_STATUS: w_rd_data = {30'b0, r_done, fft_busy};
      IDX_ID:     w_rd_data = C_IP_ID;
      default:    w_rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (r_arready && s00_axi.arvalid) begin
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
            r_rvalid   <= 1'b1;
            r_arready  <= 1'b0;
            r_rd_state <= RD_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s00_axi.rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_wready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = r_rresp;
  assign fft_start       = r_fft_start;
  assign fft_cfg0        = r_rw[1];
  assign fft_cfg1        = r_rw[2];
  assign fft_cfg2        = r_rw[3];

endmodule
